// File: rtl/l1ca_acq_scheduler_if.sv
// Bus bundle between the acquisition scheduler, the shared search engine and
// the tracking-channel allocator that drains the result FIFO.
//
// Handshakes:
//   search: srch_start is a one-cycle request carrying srch_sv. The engine
//   drops srch_done to acknowledge it, then raises srch_done (level) when
//   srch_acc/srch_code/srch_dop are valid. Those stay stable while done is high.
//   result: a transfer happens on every cycle where res_valid & res_ready are
//   both high. res_* are stable while res_valid is high and no pop occurs.
//   res_valid never waits on res_ready.
interface l1ca_acq_scheduler_if;
  logic        srch_start;
  logic [4:0]  srch_sv;
  logic        srch_done;
  logic [31:0] srch_acc;
  logic [10:0] srch_code;
  logic [4:0]  srch_dop;

  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_sv;
  logic [31:0] res_acc;
  logic [10:0] res_code;
  logic [4:0]  res_dop;

  modport master (
    output srch_start, srch_sv,
    input  srch_done, srch_acc, srch_code, srch_dop,
    output res_valid, res_sv, res_acc, res_code, res_dop,
    input  res_ready
  );

  modport slave (
    input  srch_start, srch_sv,
    output srch_done, srch_acc, srch_code, srch_dop,
    input  res_valid, res_sv, res_acc, res_code, res_dop,
    output res_ready
  );
endinterface

// File: rtl/l1ca_acq_scheduler.sv
// L1 C/A acquisition sequencer: sweeps the PRN mask, runs one search per
// enabled SV on the shared engine, and queues above-threshold peaks in a small
// result FIFO for the channel allocator.
module l1ca_acq_scheduler #(
  parameter int FIFO_DEPTH       = 4,
  parameter int START_ACK_CYCLES = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_run,
  input  logic                 i_abort,
  input  logic [31:0]          i_cfg_sv_mask,
  input  logic [31:0]          i_cfg_threshold,
  output logic                 o_busy,
  output logic                 o_sweep_done,
  output logic                 o_sweep_aborted,
  output logic                 o_timeout_err,
  output logic [5:0]           o_found_cnt,
  output logic [2:0]           o_dbg_state,
  l1ca_acq_scheduler_if.master bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ACK_W = $clog2(START_ACK_CYCLES) + 1;
  localparam int ENT_W = 5 + 32 + 11 + 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SELECT    = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_EVAL      = 3'd5,
    S_PUSH      = 3'd6,
    S_FINISH    = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [31:0]      r_mask;
  logic [31:0]      r_thr;
  logic [4:0]       r_idx;
  logic             r_abort_pend;
  logic             r_timeout_err;
  logic [5:0]       r_found_cnt;
  logic [ACK_W-1:0] r_ack_cnt;

  logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_accept_run;
  logic             w_idx_inc;
  logic             w_push;
  logic             w_pop;
  logic             w_timeout;
  logic             w_fifo_full;
  logic             w_last_idx;
  logic             w_acc_hit;
  logic             w_ack_expired;

  assign w_fifo_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_last_idx    = (r_idx == 5'd31);
  assign w_acc_hit     = (bus.srch_acc >= r_thr);
  assign w_ack_expired = (r_ack_cnt == ACK_W'(START_ACK_CYCLES - 1));
  assign w_pop         = bus.res_valid & bus.res_ready;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    w_state_next = r_state;
    w_accept_run = 1'b0;
    w_idx_inc    = 1'b0;
    w_push       = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_accept_run = 1'b1;
          w_state_next = S_SELECT;
        end
      end
      S_SELECT: begin
        if (r_abort_pend) begin
          w_state_next = S_FINISH;
        end else if (r_mask[r_idx]) begin
          w_state_next = S_START;
        end else if (w_last_idx) begin
          w_state_next = S_FINISH;
        end else begin
          w_idx_inc = 1'b1;
        end
      end
      S_START: begin
        w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // The engine's done flag is still high from the previous search;
        // its drop is the acknowledge of our start.
        if (!bus.srch_done) begin
          w_state_next = S_WAIT_DONE;
        end else if (w_ack_expired) begin
          w_timeout    = 1'b1;
          w_state_next = S_FINISH;
        end
      end
      S_WAIT_DONE: begin
        if (bus.srch_done) begin
          w_state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        if (r_abort_pend) begin
          w_state_next = S_FINISH;
        end else if (w_acc_hit) begin
          w_state_next = S_PUSH;
        end else if (w_last_idx) begin
          w_state_next = S_FINISH;
        end else begin
          w_idx_inc    = 1'b1;
          w_state_next = S_SELECT;
        end
      end
      S_PUSH: begin
        // Results are never dropped: hold here until the FIFO has room.
        if (!w_fifo_full) begin
          w_push = 1'b1;
          if (w_last_idx) begin
            w_state_next = S_FINISH;
          end else begin
            w_idx_inc    = 1'b1;
            w_state_next = S_SELECT;
          end
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sweep configuration, SV index, abort/timeout flags and found counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mask        <= '0;
      r_thr         <= '0;
      r_idx         <= '0;
      r_abort_pend  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_found_cnt   <= '0;
    end else if (w_accept_run) begin
      r_mask        <= i_cfg_sv_mask;
      r_thr         <= i_cfg_threshold;
      r_idx         <= '0;
      r_abort_pend  <= 1'b0;
      r_timeout_err <= 1'b0;
      r_found_cnt   <= '0;
    end else begin
      if (w_idx_inc) begin
        r_idx <= r_idx + 5'd1;
      end
      if ((r_state != S_IDLE) && i_abort) begin
        r_abort_pend <= 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        r_abort_pend  <= 1'b1;
      end
      if (w_push) begin
        r_found_cnt <= r_found_cnt + 6'd1;
      end
    end
  end

  // Start-acknowledge counter: cleared while issuing the start, counts WAIT_BUSY cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack_cnt <= '0;
    end else if (r_state == S_START) begin
      r_ack_cnt <= '0;
    end else if (r_state == S_WAIT_BUSY) begin
      r_ack_cnt <= r_ack_cnt + ACK_W'(1);
    end
  end

  // Result FIFO: circular buffer with registered pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {r_idx, bus.srch_acc, bus.srch_code, bus.srch_dop};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_busy          = (r_state != S_IDLE);
  assign o_sweep_done    = (r_state == S_FINISH);
  assign o_sweep_aborted = (r_state == S_FINISH) & r_abort_pend;
  assign o_timeout_err   = r_timeout_err;
  assign o_found_cnt     = r_found_cnt;
  assign o_dbg_state     = r_state;

  assign bus.srch_start = (r_state == S_START);
  assign bus.srch_sv    = r_idx;
  assign bus.res_valid  = (r_count != '0);
  assign {bus.res_sv, bus.res_acc, bus.res_code, bus.res_dop} = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_l1ca_acq_scheduler.sv
// Bench for l1ca_acq_scheduler: engine and consumer models, a sweep-level
// reference model (expected start list, expected result queue, expected
// per-sweep counts) and one negedge compare process.
`timescale 1ns/1ps
module tb_l1ca_acq_scheduler;
  localparam int FIFO_DEPTH       = 4;
  localparam int START_ACK_CYCLES = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        abort;
  logic [31:0] cfg_sv_mask;
  logic [31:0] cfg_threshold;
  logic        busy;
  logic        sweep_done;
  logic        sweep_aborted;
  logic        timeout_err;
  logic [5:0]  found_cnt;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  l1ca_acq_scheduler_if bus ();

  l1ca_acq_scheduler #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .START_ACK_CYCLES(START_ACK_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_run(run),
    .i_abort(abort),
    .i_cfg_sv_mask(cfg_sv_mask),
    .i_cfg_threshold(cfg_threshold),
    .o_busy(busy),
    .o_sweep_done(sweep_done),
    .o_sweep_aborted(sweep_aborted),
    .o_timeout_err(timeout_err),
    .o_found_cnt(found_cnt),
    .o_dbg_state(dbg_state),
    .bus(bus.master)
  );

  // ---------------- scoreboard / model state ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  logic [52:0] exp_q[$];
  int          exp_start_q[$];
  int          exp_found    = 0;
  logic        exp_aborted  = 1'b0;
  logic        exp_timeout  = 1'b0;
  logic [31:0] model_thr    = '0;
  logic        model_accept = 1'b0;
  int          sweep_cnt    = 0;
  int          starts_seen  = 0;
  int          done_cyc     = 0;
  int          run_cyc      = 0;
  int          res_rise_cyc = 0;
  int          eng_done_cyc = 0;

  // engine / consumer controls
  logic        eng_hold     = 1'b0;
  logic        eng_rand     = 1'b0;
  int          eng_drop_dly = 2;
  int          eng_run_dly  = 6;
  logic [31:0] acc_q[$];
  logic [10:0] code_q[$];
  logic [4:0]  dop_q[$];
  int          ready_mode   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- search engine model ----------------
  initial begin
    logic [4:0]  sv;
    logic [31:0] acc;
    logic [10:0] code;
    logic [4:0]  dop;
    int          d1;
    int          d2;
    bus.srch_done = 1'b1;
    bus.srch_acc  = '0;
    bus.srch_code = '0;
    bus.srch_dop  = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.srch_start && !eng_hold) begin
        sv = bus.srch_sv;
        if (acc_q.size() > 0) begin
          acc  = acc_q.pop_front();
          code = code_q.pop_front();
          dop  = dop_q.pop_front();
        end else begin
          acc  = $urandom_range(0, 1000);
          code = 11'($urandom_range(0, 2045));
          dop  = 5'($urandom_range(0, 31));
        end
        d1 = eng_rand ? $urandom_range(1, 3) : eng_drop_dly;
        d2 = eng_rand ? $urandom_range(1, 8) : eng_run_dly;
        repeat (d1) @(posedge clk);
        #1 bus.srch_done = 1'b0;
        repeat (d2) @(posedge clk);
        #1;
        bus.srch_acc  = acc;
        bus.srch_code = code;
        bus.srch_dop  = dop;
        bus.srch_done = 1'b1;
        eng_done_cyc  = cyc;
        if (model_accept && (acc >= model_thr)) begin
          exp_q.push_back({sv, acc, code, dop});
          exp_found++;
        end
      end
    end
  end

  // ---------------- consumer model ----------------
  initial begin
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        2:       bus.res_ready = 1'b1;
        default: bus.res_ready = 1'b0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;
    logic [52:0] exp_ent;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.srch_start) begin
          starts_seen++;
          chk("start_single_cycle", prev_start, 0);
          chk("start_pending", exp_start_q.size() > 0, 1);
          if (exp_start_q.size() > 0) chk("start_sv", bus.srch_sv, exp_start_q.pop_front());
        end
        if (bus.res_valid) chk("res_valid_backed", exp_q.size() > 0, 1);
        if (bus.res_valid && bus.res_ready && exp_q.size() > 0) begin
          exp_ent = exp_q.pop_front();
          chk("res_head", {bus.res_sv, bus.res_acc, bus.res_code, bus.res_dop}, exp_ent);
        end
        if (bus.res_valid && !prev_valid) res_rise_cyc = cyc;
        if (sweep_done) begin
          sweep_cnt++;
          done_cyc = cyc;
          chk("sweep_found_cnt", found_cnt, exp_found);
          chk("sweep_aborted", sweep_aborted, exp_aborted);
          chk("sweep_timeout_err", timeout_err, exp_timeout);
          chk("sweep_busy", busy, 1);
        end
      end
      prev_start = bus.srch_start;
      prev_valid = bus.res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_run(input logic [31:0] mask, input logic [31:0] thr, input logic with_abort);
    @(posedge clk);
    #1;
    cfg_sv_mask   = mask;
    cfg_threshold = thr;
    run           = 1'b1;
    abort         = with_abort;
    exp_start_q.delete();
    for (int k = 0; k < 32; k++) if (mask[k]) exp_start_q.push_back(k);
    exp_found    = 0;
    exp_aborted  = 1'b0;
    exp_timeout  = 1'b0;
    model_thr    = thr;
    model_accept = 1'b1;
    run_cyc      = cyc;
    @(posedge clk);
    #1;
    run           = 1'b0;
    abort         = 1'b0;
    cfg_sv_mask   = $urandom();
    cfg_threshold = $urandom();
  endtask

  task automatic wait_sweep(input string name, input int budget);
    int s0 = sweep_cnt;
    int n  = 0;
    while (sweep_cnt == s0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_sweep_done_seen"}, sweep_cnt != s0, 1);
    chk({name, "_all_starts_issued"}, exp_start_q.size(), 0);
  endtask

  task automatic wait_starts(input int base, input int want, input int budget);
    int n = 0;
    while (starts_seen - base < want && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("starts_reached", starts_seen - base, want);
  endtask

  task automatic drain(input string name);
    int n = 0;
    ready_mode = 2;
    while ((exp_q.size() != 0 || bus.res_valid) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_drained_model"}, exp_q.size(), 0);
    chk({name, "_drained_dut"}, bus.res_valid, 0);
  endtask

  task automatic push_eng(input logic [31:0] acc, input logic [10:0] code, input logic [4:0] dop);
    acc_q.push_back(acc);
    code_q.push_back(code);
    dop_q.push_back(dop);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s0;
    rst = 1'b1;
    run = 1'b0;
    abort = 1'b0;
    cfg_sv_mask = '0;
    cfg_threshold = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_sweep_done", sweep_done, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_found_cnt", found_cnt, 0);
    chk("reset_srch_start", bus.srch_start, 0);
    chk("reset_res_valid", bus.res_valid, 0);
    chk("reset_dbg_state", dbg_state, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single SV
    push_eng(32'd500, 11'd37, 5'd12);
    ready_mode = 0;
    s0 = starts_seen;
    do_run(32'h0000_0001, 32'd100, 1'b0);
    wait_sweep("single", 200);
    chk("single_starts", starts_seen - s0, 1);
    chk("single_found_lit", found_cnt, 1);
    chk("single_head_lit", {bus.res_sv, bus.res_acc, bus.res_code, bus.res_dop},
        {5'd0, 32'd500, 11'd37, 5'd12});
    chk("single_push_latency", res_rise_cyc - eng_done_cyc, 3);
    drain("single");

    // threshold filtering, >= compare
    push_eng(32'd50, 11'd1, 5'd1);
    push_eng(32'd100, 11'd2, 5'd2);
    push_eng(32'd99, 11'd3, 5'd3);
    ready_mode = 0;
    s0 = starts_seen;
    do_run(32'h8000_0005, 32'd100, 1'b0);
    wait_sweep("thresh", 400);
    chk("thresh_starts", starts_seen - s0, 3);
    chk("thresh_found_lit", found_cnt, 1);
    chk("thresh_head_lit", {bus.res_sv, bus.res_acc}, {5'd2, 32'd100});
    drain("thresh");

    // last SV: FINISH one cycle after PUSH
    push_eng(32'd5, 11'd9, 5'd9);
    do_run(32'h8000_0000, 32'd0, 1'b0);
    wait_sweep("last_sv", 200);
    chk("last_sv_finish_latency", done_cyc - eng_done_cyc, 3);
    drain("last_sv");

    // FIFO backpressure: 6 hits into 4 entries
    ready_mode = 0;
    s0 = starts_seen;
    do_run(32'h0000_003F, 32'd0, 1'b0);
    repeat (150) @(negedge clk);
    #1;
    chk("stall_starts", starts_seen - s0, 5);
    chk("stall_busy", busy, 1);
    chk("stall_found_cnt", found_cnt, 4);
    chk("stall_res_valid", bus.res_valid, 1);
    chk("stall_model_depth", exp_q.size(), 5);
    ready_mode = 2;
    wait_sweep("stall", 400);
    chk("stall_found_lit", found_cnt, 6);
    drain("stall");

    // abort during WAIT_DONE of the 2nd of 3 SVs
    eng_run_dly = 20;
    ready_mode = 2;
    s0 = starts_seen;
    do_run(32'h0000_0015, 32'd0, 1'b0);
    wait_starts(s0, 2, 300);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    model_accept = 1'b0;
    exp_start_q.delete();
    exp_aborted = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    wait_sweep("abort", 200);
    chk("abort_starts", starts_seen - s0, 2);
    chk("abort_found_lit", found_cnt, 1);
    eng_run_dly = 6;
    drain("abort");

    // start-acknowledge timeout: engine never drops done
    eng_hold = 1'b1;
    do_run(32'h0000_0001, 32'd0, 1'b0);
    exp_timeout = 1'b1;
    exp_aborted = 1'b1;
    wait_sweep("timeout", 200);
    chk("timeout_finish_cycle", done_cyc - run_cyc, 19);
    repeat (3) @(negedge clk);
    #1;
    chk("timeout_sticky", timeout_err, 1);
    chk("timeout_idle", busy, 0);
    eng_hold = 1'b0;

    // empty mask; run also clears timeout_err
    do_run(32'h0, 32'd0, 1'b0);
    chk("empty_busy_after_run", busy, 1);
    chk("empty_timeout_cleared", timeout_err, 0);
    wait_sweep("empty", 100);
    chk("empty_finish_cycle", done_cyc - run_cyc, 33);
    chk("empty_busy_in_finish", busy, 1);
    @(negedge clk);
    #1;
    chk("empty_busy_after", busy, 0);

    // run and abort together in IDLE: run wins
    push_eng(32'd300, 11'd44, 5'd7);
    do_run(32'h0000_0001, 32'd200, 1'b1);
    wait_sweep("run_abort", 300);
    chk("run_abort_found_lit", found_cnt, 1);
    drain("run_abort");

    // randomized sweeps
    eng_rand = 1'b1;
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      do_run($urandom() & $urandom() & $urandom(), $urandom_range(0, 1000), 1'b0);
      wait_sweep("rand", 3000);
    end
    drain("rand");
    eng_rand = 1'b0;

    // reset during WAIT_DONE with a result held in the FIFO
    ready_mode = 0;
    push_eng(32'd777, 11'd5, 5'd6);
    do_run(32'h0000_0001, 32'd0, 1'b0);
    wait_sweep("rst_fill", 300);
    eng_run_dly = 30;
    s0 = starts_seen;
    do_run(32'h0000_0002, 32'd0, 1'b0);
    wait_starts(s0, 1, 100);
    repeat (5) @(negedge clk);
    #1;
    chk("rst_pre_res_valid", bus.res_valid, 1);
    chk("rst_pre_srch_sv", bus.srch_sv, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_accept = 1'b0;
    exp_q.delete();
    exp_start_q.delete();
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_sweep_done", sweep_done, 0);
    chk("rst_sweep_aborted", sweep_aborted, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_found_cnt", found_cnt, 0);
    chk("rst_srch_start", bus.srch_start, 0);
    chk("rst_srch_sv", bus.srch_sv, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_fields", {bus.res_sv, bus.res_acc, bus.res_code, bus.res_dop}, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("rst_after_engine_done", bus.res_valid, 0);
    chk("rst_stays_idle", busy, 0);
    eng_run_dly = 6;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/l1ca_acq_scheduler.md
# l1ca_acq_scheduler

Sequencer for the L1 C/A acquisition engine (`l1ca_search`). Sweeps a configurable set of PRNs, issues one search per enabled SV, waits for completion, and compares each peak power against a threshold. SVs above threshold go into a small result FIFO that the tracking-channel allocator drains. Sits between the host/config registers and the single shared search engine.

## Interface
- `FIFO_DEPTH`, 4: result FIFO entries (power of 2, ≥2).
- `START_ACK_CYCLES`, 16: maximum cycles allowed for the engine to drop `srch_done` after `srch_start`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `run`  in  1  start-sweep pulse; honoured only in IDLE.
- `abort`  in  1  abort-sweep pulse; ignored in IDLE.
- `cfg_sv_mask`  in  32  bit k set = search PRN k+1; sampled on accepted `run`.
- `cfg_threshold`  in  32  unsigned power threshold; sampled on accepted `run`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `sweep_done`  out  1  one-cycle pulse at sweep end.
- `sweep_aborted`  out  1  valid with `sweep_done`: sweep ended by abort or timeout.
- `timeout_err`  out  1  sticky; cleared on accepted `run` or `rst`.
- `found_cnt`  out  6  results pushed this sweep; cleared on accepted `run`.
- `srch_start`  out  1  one-cycle start to engine.
- `srch_sv`  out  5  PRN−1 presented to engine; held stable from START through EVAL.
- `srch_done`  in  1  engine done level.
- `srch_acc`  in  32  engine peak I²+Q².
- `srch_code`  in  11  engine half-chip index of the peak.
- `srch_dop`  in  5  engine Doppler bin of the peak.
- `res_valid`  out  1  FIFO not empty.
- `res_ready`  in  1  consumer pop; pop occurs when `res_valid & res_ready`.
- `res_sv`, `res_acc`, `res_code`, `res_dop`  out  5/32/11/5  FIFO head.

## Operation
- States: IDLE, SELECT, START, WAIT_BUSY, WAIT_DONE, EVAL, PUSH, FINISH.
- **IDLE:** on `run`, latch mask and threshold, set idx=0, clear `found_cnt`, `timeout_err` and abort_pend, then go to SELECT.
- **SELECT:** examines one mask bit per cycle.
  - abort_pend → FINISH.
  - mask[idx] set → START.
  - Otherwise, idx=31 → FINISH; else idx+1.
- **START:** `srch_start`=1 for exactly one cycle, `srch_sv`=idx; then WAIT_BUSY.
- **WAIT_BUSY:** wait for `srch_done`=0. This is required because the engine's done flag stays high from the previous search.
  - If done is still high after `START_ACK_CYCLES` cycles, set `timeout_err`, set sweep_aborted, and go to FINISH.
- **WAIT_DONE:** wait for `srch_done`=1, then go to EVAL. There is no timeout here, because a search takes roughly 4×10⁷ cycles.
- **EVAL:**
  - abort_pend → discard the result, go to FINISH.
  - `srch_acc` ≥ threshold (unsigned) → PUSH.
  - Otherwise, advance as SELECT does: idx=31 → FINISH, else idx+1 → SELECT.
- **PUSH:** when FIFO count < `FIFO_DEPTH`, write {idx, acc, code, dop}, increment `found_cnt`, and advance idx as in EVAL. Otherwise stall in PUSH; results are never dropped.
- **FINISH:** `sweep_done`=1 for one cycle, `sweep_aborted`=abort_pend, then go to IDLE.
- **abort:** sets abort_pend in any non-IDLE state. An in-flight search always runs to completion, because the engine has no abort. Abort does not release a PUSH stall that is already in progress; the entry is still written.
- **FIFO:**
  - Circular buffer with registered pointers and a count.
  - Push and pop in the same cycle leave the count unchanged.
  - A push into a full FIFO is not performed; PUSH stalls instead.
  - Contents survive sweeps and aborts and are cleared only by `rst`.
- **rst mid-sweep:** forces IDLE, empties the FIFO, and clears all outputs. Any engine search in progress is not tracked.

## Timing
- **Reset values:** all outputs 0; state IDLE; FIFO empty.
- **Start of sweep:** `run` accepted at edge N gives `busy`=1 from N+1, with SELECT on idx 0 at N+1.
- **Empty mask:** SELECT occupies N+1..N+32, FINISH (`sweep_done`) at N+33, `busy`=0 at N+34.
- **SV latency:** from SELECT hit, START is on the next cycle; `srch_start` is registered and sees `srch_done` effect one cycle later.
- **End of search:** EVAL comes one cycle after `srch_done` rises. PUSH, if taken, writes at the following edge; `res_valid` rises the cycle after that write.
- **Last SV:** SV 32 with an empty FIFO gives FINISH one cycle after PUSH.
- **Simultaneous run and abort in IDLE:** the run is accepted and the abort ignored.
- **Pop:** `res_*` update the cycle after a pop.

## Test plan
- **Single SV:** mask=0x1, threshold=100; engine model returns acc=500, code=37, dop=12 → one `srch_start` with `srch_sv`=0; FIFO entry {0,500,37,12}; `found_cnt`=1; `sweep_done` with `sweep_aborted`=0.
- **Threshold filtering:** mask=0x8000_0005, acc values 50/100/99 against threshold 100 → exactly 3 starts (sv 0,2,31); one entry (sv 2), confirming ≥ compare; `found_cnt`=1.
- **FIFO backpressure:** `FIFO_DEPTH`=4, 6 SVs all above threshold, `res_ready`=0 → stall in PUSH after 4 entries with no 6th start issued. Raising `res_ready` drains in order; all 6 entries are delivered with none lost.
- **Abort mid-search:** abort during WAIT_DONE of the 2nd of 3 SVs → its result is discarded; no 3rd start; `sweep_done` with `sweep_aborted`=1.
- **Start timeout:** engine holds `srch_done`=1 → `timeout_err`=1 after 16 cycles in WAIT_BUSY; sweep ends aborted. A following `run` clears `timeout_err`.
- **Empty mask and reset:** mask=0 → `sweep_done` exactly 33 cycles after `run`. A separate case asserts `rst` during WAIT_DONE → all outputs 0 and FIFO empty the next cycle.
